// File: rtl/unit_a_chunked.sv
// Multi-cycle chunked add/sub unit: ADD/SUB/NEG/INC with carry chaining,
// CHUNK bits per cycle through one shared adder slice, N/Z/C/V flags.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_ready   operand handshake (a, b, f)
//   f[1:0] op, f[2] carry-chain select, f[3] ignored
//   out_valid, out_ready result handshake (s, c_out, flag_*)
module unit_a_chunked #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_width
         $error("unit_a_chunked: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             zacc;
   logic [KW-1:0]    k;

   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK-1:0] sum;
   logic             c_nx;
   logic             msb_cin;
   logic             last;
   logic [WIDTH-1:0] res;
   logic             cin;
   logic             unused_f;

   assign unused_f = f[3];

   // ADC/SBC only when the op actually uses operand A
   assign cin = (f[2] && !f[1]) ? flag_c : (f[1] | f[0]);

   assign a_ch = a_r[int'(k)*CHUNK +: CHUNK];
   assign b_ch = b_r[int'(k)*CHUNK +: CHUNK];
   assign {c_nx, sum} = {1'b0, a_ch} + {1'b0, b_ch}
                      + {{CHUNK{1'b0}}, carry};

   // carry into the slice MSB recovered from its sum bit
   assign msb_cin = sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
   assign last    = (k == KW'(NCH - 1));

   always_comb begin
      res = acc;
      res[int'(k)*CHUNK +: CHUNK] = sum;
   end

   assign c_out = flag_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         zacc      <= 1'b0;
         k         <= '0;
         s         <= '0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a & ~{WIDTH{f[1]}};
                  b_r      <= b ^ {WIDTH{f[1] ^ f[0]}};
                  carry    <= cin;
                  k        <= '0;
                  zacc     <= 1'b1;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               carry <= c_nx;
               zacc  <= zacc & (sum == '0);
               acc   <= res;
               k     <= k + KW'(1);
               if (last) begin
                  // result and flags only become visible here
                  s         <= res;
                  flag_n    <= res[WIDTH-1];
                  flag_z    <= zacc & (sum == '0);
                  flag_c    <= c_nx;
                  flag_v    <= msb_cin ^ c_nx;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unit_a_chunked.sv
// Testbench for unit_a_chunked: 32/8 and 16/16 instances,
// directed table, handshake/reset sequences, random vs model.
module tb_unit_a_chunked;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit, 8-bit chunks
   logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0, s32;
   logic [3:0]  f32 = '0;
   logic        co32, n32, z32, c32, v32;

   // 16-bit, single chunk
   logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, s16;
   logic [3:0]  f16 = '0;
   logic        co16, n16, z16, c16, v16;

   unit_a_chunked #(.WIDTH(32), .CHUNK(8)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .f(f32),
      .out_valid(ov32), .out_ready(or32),
      .s(s32), .c_out(co32),
      .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
   );

   unit_a_chunked #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .f(f16),
      .out_valid(ov16), .out_ready(or16),
      .s(s16), .c_out(co16),
      .flag_n(n16), .flag_z(z16), .flag_c(c16), .flag_v(v16)
   );

   int passed = 0;
   int total  = 0;
   int sel    = 0;

   logic [31:0] cs;
   logic        cir, cov, cco;
   logic [3:0]  cfl;

   always_comb begin
      if (sel == 0) begin
         cs = s32; cir = ir32; cov = ov32; cco = co32;
         cfl = {n32, z32, c32, v32};
      end else begin
         cs = {16'h0, s16}; cir = ir16; cov = ov16; cco = co16;
         cfl = {n16, z16, c16, v16};
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: plain arithmetic on w-bit unsigned values
   function automatic void model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] f,
                                 input logic cf, output logic [31:0] s,
                                 output logic [3:0] fl);
      logic [63:0] mask, x, y, r;
      logic        ci, n, z, c, v;
      mask = (64'd1 << w) - 64'd1;
      case (f[1:0])
         2'd0: begin x = 64'(a) & mask; y = 64'(b) & mask; ci = 0; end
         2'd1: begin x = 64'(a) & mask; y = ~64'(b) & mask; ci = 1; end
         2'd2: begin x = 0; y = ~64'(b) & mask; ci = 1; end
         default: begin x = 0; y = 64'(b) & mask; ci = 1; end
      endcase
      if (f[2] && !f[1]) ci = cf;
      r = x + y + 64'(ci);
      c = r[w];
      r = r & mask;
      s = 32'(r);
      n = r[w-1];
      z = (r == 0);
      v = (x[w-1] == y[w-1]) && (n != x[w-1]);
      fl = {n, z, c, v};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic v);
      if (sel == 0) begin a32 = a; b32 = b; f32 = f; iv32 = v; end
      else begin a16 = a[15:0]; b16 = b[15:0]; f16 = f; iv16 = v; end
   endtask

   task automatic set_ordy(input logic v);
      if (sel == 0) or32 = v; else or16 = v;
   endtask

   // Issue one op; returns cycles from accept edge to out_valid (-1 on timeout)
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, output int lat);
      chk("accept_ready", 64'(cir), 64'd1);
      drive(a, b, f, 1'b1);
      @(posedge clk); #1;
      drive(a, b, f, 1'b0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (cov) begin lat = i - 1; break; end
         @(posedge clk); #1;
      end
      if (lat < 0 && cov) lat = 20;
   endtask

   task automatic release_out();
      logic [31:0] s_hold;
      s_hold = cs;
      set_ordy(1'b1);
      @(posedge clk); #1;
      set_ordy(1'b0);
      chk("rel_out_valid", 64'(cov), 64'd0);
      chk("rel_in_ready", 64'(cir), 64'd1);
      chk("rel_s_hold", 64'(cs), 64'(s_hold));
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  f;
      logic [31:0] s;
      logic [3:0]  fl;  // {n,z,c,v}
   } vec_t;

   vec_t        tbl[5];
   logic        mc32 = 1'b0, mc16 = 1'b0;
   logic [31:0] es;
   logic [3:0]  efl;
   int          lat;

   initial begin
      tbl[0] = '{32'h00000001, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 4'b0110};
      tbl[1] = '{32'h80000000, 32'h00000001, 4'b0001, 32'h7FFFFFFF, 4'b0011};
      tbl[2] = '{32'h12345678, 32'h00000005, 4'b0010, 32'hFFFFFFFB, 4'b1000};
      tbl[3] = '{32'hDEADBEEF, 32'hFFFFFFFF, 4'b0011, 32'h00000000, 4'b0110};
      tbl[4] = '{32'h00000000, 32'h00000000, 4'b0100, 32'h00000001, 4'b0000};

      // reset state
      #12;
      chk("rst_out_valid", 64'(ov32), 64'd0);
      chk("rst_s", 64'(s32), 64'd0);
      chk("rst_flags", 64'({n32, z32, c32, v32, co32}), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(ir32), 64'd1);

      // directed table
      sel = 0;
      for (int i = 0; i < 5; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].f, lat);
         chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd4);
         chk($sformatf("tbl%0d_s", i), 64'(cs), 64'(tbl[i].s));
         chk($sformatf("tbl%0d_flags", i), 64'(cfl), 64'(tbl[i].fl));
         chk($sformatf("tbl%0d_cout", i), 64'(cco), 64'(tbl[i].fl[1]));
         mc32 = tbl[i].fl[1];
         release_out();
      end

      // backpressure: hold DONE, pulse in_valid
      run_op(32'h0000FFFF, 32'h00000001, 4'b0000, lat);
      model(32, 32'h0000FFFF, 32'h00000001, 4'b0000, mc32, es, efl);
      mc32 = efl[1];
      for (int i = 0; i < 3; i++) begin
         drive(32'h11111111, 32'h22222222, 4'b0000, i == 1);
         @(posedge clk); #1;
         chk("bp_out_valid", 64'(cov), 64'd1);
         chk("bp_in_ready", 64'(cir), 64'd0);
         chk("bp_s", 64'(cs), 64'(es));
         chk("bp_flags", 64'(cfl), 64'(efl));
      end
      drive(32'h0, 32'h0, 4'b0000, 1'b0);
      release_out();
      repeat (6) @(posedge clk);
      #1;
      chk("bp_no_extra", 64'(cov), 64'd0);

      // reset in the second RUN cycle
      chk("mr_ready", 64'(cir), 64'd1);
      drive(32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000, 1'b1);
      @(posedge clk); #1;
      drive(32'h0, 32'h0, 4'b0000, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 64'(ov32), 64'd0);
      chk("mr_s", 64'(s32), 64'd0);
      chk("mr_flags", 64'({n32, z32, c32, v32, co32}), 64'd0);
      mc32 = 1'b0; mc16 = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mr_in_ready", 64'(ir32), 64'd1);
      chk("mr_no_result", 64'(ov32), 64'd0);
      run_op(32'd3, 32'd4, 4'b0000, lat);
      chk("mr_add_lat", 64'(lat), 64'd4);
      chk("mr_add_s", 64'(cs), 64'd7);
      release_out();

      // random vs model, 32/8
      for (int i = 0; i < 30; i++) begin
         logic [31:0] ra, rb;
         logic [3:0]  rf;
         ra = $urandom; rb = $urandom; rf = 4'($urandom);
         if (i % 5 == 0) rb = ~ra;
         model(32, ra, rb, rf, mc32, es, efl);
         run_op(ra, rb, rf, lat);
         chk($sformatf("r32_%0d_lat", i), 64'(lat), 64'd4);
         chk($sformatf("r32_%0d_s", i), 64'(cs), 64'(es));
         chk($sformatf("r32_%0d_flags", i), 64'(cfl), 64'(efl));
         chk($sformatf("r32_%0d_cout", i), 64'(cco), 64'(efl[1]));
         mc32 = efl[1];
         release_out();
      end

      // 16/16 single-cycle
      sel = 1;
      run_op(32'h7FFF, 32'h0001, 4'b0000, lat);
      chk("w16_lat", 64'(lat), 64'd1);
      chk("w16_s", 64'(cs), 64'h8000);
      chk("w16_flags", 64'(cfl), 64'b1001);
      mc16 = 1'b0;
      release_out();
      for (int i = 0; i < 12; i++) begin
         logic [31:0] ra, rb;
         logic [3:0]  rf;
         ra = $urandom; rb = $urandom; rf = 4'($urandom);
         model(16, ra, rb, rf, mc16, es, efl);
         run_op(ra, rb, rf, lat);
         chk($sformatf("r16_%0d_lat", i), 64'(lat), 64'd1);
         chk($sformatf("r16_%0d_s", i), 64'(cs), 64'(es));
         chk($sformatf("r16_%0d_flags", i), 64'(cfl), 64'(efl));
         mc16 = efl[1];
         release_out();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
